memory_arbiter: RTL and testbench

Responder side of the CPU memory request interface. Accepts instruction-fetch requests (imemREN) and data requests (dmemREN/dmemWEN) from the request unit and serialises them onto one single-ported RAM. Returns ihit/dhit with the load data. Sits between the datapath request unit and the RAM model.

---
 rtl/memory_arbiter.sv | 141 ++++++++++++++
 tb/tb_memory_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Serialises instruction-fetch and data requests onto one single-ported RAM.
// Data requests win arbitration; every access ends with a one-cycle hit pulse.
module memory_arbiter #(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    output logic              ihit,
    output logic [WORD_W-1:0] imemload,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [WORD_W-1:0] dmemaddr,
    input  logic [WORD_W-1:0] dmemstore,
    output logic              dhit,
    output logic [WORD_W-1:0] dmemload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic              ramready,
    output logic              err
);

    localparam logic [WORD_W-1:0] BAD_WORD = WORD_W'(32'hBAD1BAD1);
    localparam logic [3:0]        LAST_CNT = 4'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DACC, IACC, RESP} state_t;

    state_t            state, nextState;
    logic [3:0]        waitCnt, cntNext;
    logic              isWrite, writeNext;
    logic              renNext, wenNext, ihitNext, dhitNext, errNext;
    logic [WORD_W-1:0] addrNext, storeNext, iloadNext, dloadNext;
    logic              dataReq, inAccess, accDone;

    assign dataReq  = dmemREN | dmemWEN;
    assign inAccess = (state == DACC) || (state == IACC);
    // The counter value TIMEOUT-1 marks the TIMEOUT-th access cycle; ramready wins a tie.
    assign accDone  = inAccess && (ramready || (waitCnt == LAST_CNT));

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!nRST) begin
            state    <= IDLE;
            waitCnt  <= '0;
            isWrite  <= 1'b0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            ihit     <= 1'b0;
            dhit     <= 1'b0;
            imemload <= '0;
            dmemload <= '0;
            err      <= 1'b0;
        end else begin
            state    <= nextState;
            waitCnt  <= cntNext;
            isWrite  <= writeNext;
            ramREN   <= renNext;
            ramWEN   <= wenNext;
            ramaddr  <= addrNext;
            ramstore <= storeNext;
            ihit     <= ihitNext;
            dhit     <= dhitNext;
            imemload <= iloadNext;
            dmemload <= dloadNext;
            err      <= errNext;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (dataReq)      nextState = DACC;
                else if (imemREN) nextState = IACC;
            end
            DACC, IACC: if (accDone) nextState = RESP;
            RESP:       nextState = IDLE;
            default:    nextState = IDLE;
        endcase
    end

    // Next values for the registered outputs, so every port comes straight from a flop.
    always_comb begin
        // NOTE: every signal gets a default first; a missed branch would otherwise infer a latch.
        cntNext   = waitCnt;
        writeNext = isWrite;
        addrNext  = ramaddr;
        storeNext = ramstore;
        errNext   = err;
        renNext   = 1'b0;
        wenNext   = 1'b0;
        ihitNext  = 1'b0;
        dhitNext  = 1'b0;
        iloadNext = '0;
        dloadNext = '0;
        case (state)
            IDLE: begin
                cntNext = '0;
                if (dataReq) begin
                    writeNext = dmemWEN;
                    addrNext  = {dmemaddr[WORD_W-1:2], 2'b00};
                    storeNext = dmemstore;
                    renNext   = ~dmemWEN;
                    wenNext   = dmemWEN;
                    if ((dmemaddr[1:0] != 2'b00) || (dmemREN && dmemWEN)) errNext = 1'b1;
                end else if (imemREN) begin
                    writeNext = 1'b0;
                    addrNext  = {imemaddr[WORD_W-1:2], 2'b00};
                    renNext   = 1'b1;
                    if (imemaddr[1:0] != 2'b00) errNext = 1'b1;
                end
            end
            DACC, IACC: begin
                if (accDone) begin
                    if (!ramready) errNext = 1'b1;
                    // The hit is dropped if the requester has withdrawn by completion.
                    if (state == DACC) begin
                        dhitNext  = dataReq;
                        dloadNext = ramready ? ramload : BAD_WORD;
                    end else begin
                        ihitNext  = imemREN;
                        iloadNext = ramready ? ramload : BAD_WORD;
                    end
                end else begin
                    cntNext = waitCnt + 4'd1;
                    renNext = ~isWrite;
                    wenNext = isWrite;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomised and directed bench for memory_arbiter: RAM model with per-access
// wait states, reference memory model and a hit scoreboard checked by a monitor.
module tb_memory_arbiter;

    localparam logic [31:0] BAD_WORD = 32'hBAD1BAD1;

    logic        CLK, nRST;
    logic        imemREN, ihit, dmemREN, dmemWEN, dhit;
    logic [31:0] imemaddr, imemload, dmemaddr, dmemstore, dmemload;
    logic        ramREN, ramWEN, ramready, err;
    logic [31:0] ramaddr, ramstore, ramload;

    memory_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit), .imemload(imemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready), .err(err)
    );

    typedef struct {
        bit          isData;
        bit          checkLoad;
        logic [31:0] load;
        int          cycle;
        bit          err;
    } hit_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] store;
        bit          wr;
    } acc_t;

    hit_t        sbQ[$];
    acc_t        accQ[$];
    int          waitQ[$];
    logic [31:0] ramMem[logic [31:0]];
    logic [31:0] refMem[logic [31:0]];
    bit          errExp;
    int          cycleCnt;
    int          numChecks = 0;
    int          numFails  = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cycleCnt <= cycleCnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        numChecks++;
        if (act !== exp) begin
            numFails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycleCnt);
        end
    endtask

    task automatic failNow(input string name);
        numChecks++;
        numFails++;
        $display("FAIL %s (cycle %0d)", name, cycleCnt);
    endtask

    function automatic logic [31:0] initWord(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13572468;
    endfunction

    function automatic logic [31:0] ramRead(input logic [31:0] a);
        return ramMem.exists(a) ? ramMem[a] : initWord(a);
    endfunction

    function automatic logic [31:0] refRead(input logic [31:0] a);
        return refMem.exists(a) ? refMem[a] : initWord(a);
    endfunction

    // RAM model: ready after the queued number of wait cycles for each new access.
    bit          ramActive = 0;
    int          curWait, waitSeen;
    acc_t        cur;
    always @(negedge CLK) begin
        if (ramREN || ramWEN) begin
            check("ram_strobe_exclusive", 32'(ramREN & ramWEN), 0);
            if (!ramActive) begin
                ramActive = 1;
                waitSeen  = 0;
                curWait   = (waitQ.size() != 0) ? waitQ.pop_front() : 0;
                cur.addr  = ramaddr;
                cur.store = ramstore;
                cur.wr    = ramWEN;
                if (accQ.size() == 0) failNow("ram_unexpected_access");
                else begin
                    acc_t a;
                    a = accQ.pop_front();
                    check("ram_addr", ramaddr, a.addr);
                    check("ram_is_write", 32'(ramWEN), 32'(a.wr));
                    if (a.wr) check("ram_store", ramstore, a.store);
                end
            end else begin
                check("ram_hold_addr", ramaddr, cur.addr);
                check("ram_hold_strobe", 32'(ramWEN), 32'(cur.wr));
                if (cur.wr) check("ram_hold_store", ramstore, cur.store);
            end
            if (waitSeen == curWait) begin
                ramready = 1'b1;
                if (ramWEN) ramMem[ramaddr] = ramstore;
                else        ramload = ramRead(ramaddr);
            end else begin
                ramready = 1'b0;
            end
            waitSeen++;
        end else begin
            ramActive = 0;
            ramready  = 1'b0;
        end
    end

    // Monitor: every hit must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        hit_t e;
        if (nRST && (ihit || dhit)) begin
            check("hit_exclusive", 32'(ihit & dhit), 0);
            if (sbQ.size() == 0) failNow("unexpected_hit");
            else begin
                e = sbQ.pop_front();
                check("hit_type", 32'(dhit), 32'(e.isData));
                check("hit_cycle", cycleCnt, e.cycle);
                if (e.checkLoad) check("hit_load", e.isData ? dmemload : imemload, e.load);
                check("hit_err", 32'(err), 32'(e.err));
            end
        end
    end

    // Reference model: 2-cycle minimum latency, one extra per RAM wait, capped by the timeout.
    task automatic expectAccess(input bit isData, input bit wr, input bit both,
                                input logic [31:0] addr, input logic [31:0] data,
                                input int w, input int issueCycle);
        hit_t        h;
        acc_t        a;
        bit          wrEff, timedOut;
        logic [31:0] aligned;
        aligned  = addr & 32'hFFFF_FFFC;
        wrEff    = isData && (wr || both);
        timedOut = (w >= 15);
        a.addr = aligned; a.store = data; a.wr = wrEff;
        accQ.push_back(a);
        waitQ.push_back(w);
        if ((addr[1:0] != 2'b00) || both || timedOut) errExp = 1;
        h.isData    = isData;
        h.checkLoad = !wrEff;
        h.load      = timedOut ? BAD_WORD : refRead(aligned);
        h.cycle     = issueCycle + 2 + ((w > 14) ? 14 : w);
        h.err       = errExp;
        if (wrEff && !timedOut) refMem[aligned] = data;
        sbQ.push_back(h);
    endtask

    task automatic waitHit(input bit isData);
        int n = 0;
        @(negedge CLK);
        while (!(isData ? dhit : ihit) && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 40) failNow(isData ? "dhit_wait_expired" : "ihit_wait_expired");
    endtask

    task automatic doAccess(input bit isData, input bit wr, input bit both,
                            input logic [31:0] addr, input logic [31:0] data, input int w);
        expectAccess(isData, wr, both, addr, data, w, cycleCnt);
        if (isData) begin
            dmemaddr  = addr;
            dmemstore = data;
            dmemREN   = !wr || both;
            dmemWEN   = wr || both;
        end else begin
            imemaddr = addr;
            imemREN  = 1'b1;
        end
        waitHit(isData);
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        imemREN = 1'b0;
        @(negedge CLK);
    endtask

    task automatic resetDut();
        @(negedge CLK);
        nRST = 1'b0;
        imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("reset_flags", {27'd0, ihit, dhit, ramREN, ramWEN, err}, 0);
        errExp = 0;
        nRST = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        cycleCnt = 0;
        errExp   = 0;
        nRST = 1'b0; ramready = 1'b0; ramload = '0;
        dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = '0; dmemstore = '0;
        imemREN = 1'b1; imemaddr = 32'h40;
        ramMem[32'h40] = 32'h8C220004;
        refMem[32'h40] = 32'h8C220004;

        // Reset held with a pending fetch, then zero-wait fetch on release.
        @(negedge CLK);
        @(negedge CLK);
        check("reset_flags", {27'd0, ihit, dhit, ramREN, ramWEN, err}, 0);
        check("reset_ramaddr", ramaddr, 0);
        check("reset_imemload", imemload, 0);
        expectAccess(0, 0, 0, 32'h40, 0, 0, cycleCnt);
        nRST = 1'b1;
        @(negedge CLK);
        check("release_ramREN", 32'(ramREN), 1);
        check("release_ramaddr", ramaddr, 32'h40);
        waitHit(0);
        imemREN = 1'b0;
        @(negedge CLK);

        // Simultaneous requests: data first (3 waits), fetch after IDLE re-entry.
        c0 = cycleCnt;
        expectAccess(1, 0, 0, 32'h100, 0, 3, c0);
        expectAccess(0, 0, 0, 32'h44, 0, 0, c0 + 6);
        imemaddr = 32'h44; imemREN = 1'b1;
        dmemaddr = 32'h100; dmemREN = 1'b1;
        waitHit(1);
        dmemREN = 1'b0;
        waitHit(0);
        imemREN = 1'b0;
        @(negedge CLK);

        doAccess(1, 1, 0, 32'h200, 32'hDEADBEEF, 4);
        doAccess(1, 0, 0, 32'h200, 0, 0);
        doAccess(1, 0, 0, 32'h204, 0, 14);
        for (int i = 0; i < 30; i++) begin
            int k;
            k = $urandom_range(0, 2);
            doAccess(k != 0, k == 2, 0, 32'h1000 + 32'($urandom_range(0, 15) << 2),
                     $urandom, $urandom_range(0, 6));
        end
        check("err_clean_run", 32'(err), 0);

        // Read and write together: performed as a write, error flagged.
        doAccess(1, 1, 1, 32'h400, 32'hCAFEF00D, 1);
        doAccess(1, 0, 0, 32'h400, 0, 0);
        resetDut();
        check("err_cleared_by_reset", 32'(err), 0);

        doAccess(1, 0, 0, 32'h1000_0103, 0, 2);
        resetDut();

        doAccess(1, 0, 0, 32'h300, 0, 99);

        // Withdrawal: access runs to completion but produces no hit.
        expectAccess(1, 0, 0, 32'h500, 0, 5, cycleCnt);
        void'(sbQ.pop_back());
        dmemaddr = 32'h500; dmemREN = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        dmemREN = 1'b0;
        repeat (12) @(negedge CLK);
        doAccess(0, 0, 0, 32'h48, 0, 1);

        check("err_sticky", 32'(err), 1);
        check("scoreboard_drained", sbQ.size(), 0);
        check("ram_accesses_drained", accQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
